// File: rtl/go_pkg.sv
// Shared Go types: cell and board encodings, move and reject-code constants,
// and the sequencer state encoding.
package go_pkg;

  typedef logic [1:0] cell_t;
  typedef cell_t [8:0][8:0] board_t;

  localparam cell_t      EMPTY       = 2'b00;
  localparam cell_t      BLACK       = 2'b01;
  localparam cell_t      WHITE       = 2'b10;
  localparam cell_t      KO_SENTINEL = 2'b11;
  localparam logic [7:0] PASS_MOVE   = 8'hFF;
  localparam board_t     KO_CLEAR    = {81{KO_SENTINEL}};

  typedef enum logic [1:0] {
    WRONG_SRC = 2'd0,
    OFF_BOARD = 2'd1,
    OCCUPIED  = 2'd2,
    ILLEGAL   = 2'd3
  } reject_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT, S_COMMIT, S_REJECT, S_OVER
  } seq_state_t;

  function automatic logic on_board(input logic [7:0] mv);
    return (mv[7:4] <= 4'd8) && (mv[3:0] <= 4'd8);
  endfunction

endpackage

// File: rtl/move_arbiter.sv
// Two-port fixed-priority valid/ready arbiter; port 0 wins, and the granted
// port index and move are held until the next grant.
module move_arbiter
  import go_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_open,
  input  logic [1:0]      i_valid,
  input  logic [1:0][7:0] i_move,
  output logic [1:0]      o_ready,
  output logic            o_grant,
  output logic            o_port,
  output logic [7:0]      o_move
);

  logic [1:0] w_hs;
  logic       r_port;
  logic [7:0] r_move;

  // Port 1 is only readied when port 0 is not competing in the same cycle.
  assign o_ready[0] = i_open;
  assign o_ready[1] = i_open & ~i_valid[0];
  assign w_hs       = i_valid & o_ready;
  assign o_grant    = |w_hs;
  assign o_port     = r_port;
  assign o_move     = r_move;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_port <= 1'b0;
      r_move <= PASS_MOVE;
    end else if (o_grant) begin
      r_port <= ~w_hs[0];
      r_move <= w_hs[0] ? i_move[0] : i_move[1];
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Per-ply sequencer for board_updater: arbitrates the two move sources,
// pre-checks each move, launches the engine and owns the committed game state.
//
// state    | meaning
// S_IDLE   | accept a request; apply a pending or live new_game first
// S_CHECK  | source / bounds / occupancy checks on the latched move
// S_LAUNCH | upd_start pulse
// S_WAIT   | waiting for the engine verdict, watchdog running
// S_COMMIT | move_done pulse, state already updated
// S_REJECT | move_reject pulse with reject_code
// S_OVER   | two consecutive passes; only new_game leaves
module game_sequencer
  import go_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MOVE_CNT_W     = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  new_game,
  input  logic [1:0]            color_src,
  input  logic [1:0]            req_valid,
  input  logic [1:0][7:0]       req_move,
  output logic [1:0]            req_ready,
  output logic                  move_done,
  output logic                  move_reject,
  output logic [1:0]            reject_code,
  output logic                  upd_start,
  output board_t                upd_board,
  output board_t                upd_ko_board,
  output logic                  upd_turn,
  output logic [7:0]            upd_move,
  input  board_t                upd_next_board,
  input  logic                  upd_valid,
  input  logic                  upd_invalid,
  output board_t                board,
  output logic                  turn,
  output logic [MOVE_CNT_W-1:0] move_count,
  output logic                  game_over,
  output logic                  timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t            r_state;
  board_t                r_board;
  board_t                r_ko;
  logic                  r_turn;
  logic [MOVE_CNT_W-1:0] r_move_count;
  logic [1:0]            r_pass_cnt;
  logic                  r_game_over;
  logic                  r_timeout_err;
  logic                  r_ng_pend;
  logic                  r_move_done;
  logic                  r_move_reject;
  reject_t               r_reject_code;
  logic                  r_upd_start;
  logic [WD_W-1:0]       r_wd_cnt;

  logic                  w_rest_state;
  logic                  w_clear;
  logic                  w_open;
  logic                  w_grant;
  logic                  w_port;
  logic [7:0]            w_move;
  logic [3:0]            w_row;
  logic [3:0]            w_col;
  logic                  w_is_pass;

  assign w_rest_state = (r_state == S_IDLE) || (r_state == S_OVER);
  assign w_clear      = w_rest_state && (new_game || r_ng_pend);
  // A restart takes the whole IDLE cycle, so no request is accepted alongside it.
  assign w_open       = (r_state == S_IDLE) && !new_game && !r_ng_pend;
  assign w_row        = w_move[7:4];
  assign w_col        = w_move[3:0];
  assign w_is_pass    = (w_move == PASS_MOVE);

  move_arbiter u_arb (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_open  (w_open),
    .i_valid (req_valid),
    .i_move  (req_move),
    .o_ready (req_ready),
    .o_grant (w_grant),
    .o_port  (w_port),
    .o_move  (w_move)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_board       <= '0;
      r_ko          <= KO_CLEAR;
      r_turn        <= 1'b0;
      r_move_count  <= '0;
      r_pass_cnt    <= '0;
      r_game_over   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_ng_pend     <= 1'b0;
      r_move_done   <= 1'b0;
      r_move_reject <= 1'b0;
      r_reject_code <= WRONG_SRC;
      r_upd_start   <= 1'b0;
      r_wd_cnt      <= '0;
    end else begin
      r_move_done   <= 1'b0;
      r_move_reject <= 1'b0;
      r_upd_start   <= 1'b0;
      if (new_game && !w_rest_state) r_ng_pend <= 1'b1;

      if (w_clear) begin
        r_state      <= S_IDLE;
        r_board      <= '0;
        r_ko         <= KO_CLEAR;
        r_turn       <= 1'b0;
        r_move_count <= '0;
        r_pass_cnt   <= '0;
        r_game_over  <= 1'b0;
        r_ng_pend    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE:   if (w_grant) r_state <= S_CHECK;
          S_CHECK: begin
            if (w_port != color_src[r_turn]) begin
              r_reject_code <= WRONG_SRC;
              r_move_reject <= 1'b1;
              r_state       <= S_REJECT;
            end else if (!w_is_pass && !on_board(w_move)) begin
              r_reject_code <= OFF_BOARD;
              r_move_reject <= 1'b1;
              r_state       <= S_REJECT;
            end else if (!w_is_pass && r_board[w_row][w_col] != EMPTY) begin
              r_reject_code <= OCCUPIED;
              r_move_reject <= 1'b1;
              r_state       <= S_REJECT;
            end else begin
              r_upd_start <= 1'b1;
              r_state     <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            r_wd_cnt <= '0;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            if (upd_invalid) begin
              r_reject_code <= ILLEGAL;
              r_move_reject <= 1'b1;
              r_state       <= S_REJECT;
            end else if (upd_valid) begin
              if (w_is_pass) begin
                r_ko       <= KO_CLEAR;
                r_pass_cnt <= r_pass_cnt + 1'b1;
              end else begin
                r_ko       <= r_board;
                r_board    <= upd_next_board;
                r_pass_cnt <= '0;
              end
              r_turn <= ~r_turn;
              if (r_move_count != '1) r_move_count <= r_move_count + 1'b1;
              r_move_done <= 1'b1;
              r_state     <= S_COMMIT;
            end else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
              r_reject_code <= ILLEGAL;
              r_move_reject <= 1'b1;
              r_timeout_err <= 1'b1;
              r_state       <= S_REJECT;
            end else begin
              r_wd_cnt <= r_wd_cnt + 1'b1;
            end
          end
          S_COMMIT: begin
            if (r_pass_cnt == 2'd2) begin
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_REJECT: r_state <= S_IDLE;
          S_OVER:   r_state <= S_OVER;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign move_done    = r_move_done;
  assign move_reject  = r_move_reject;
  assign reject_code  = r_reject_code;
  assign upd_start    = r_upd_start;
  assign upd_board    = r_board;
  assign upd_ko_board = r_ko;
  assign upd_turn     = r_turn;
  assign upd_move     = w_move;
  assign board        = r_board;
  assign turn         = r_turn;
  assign move_count   = r_move_count;
  assign game_over    = r_game_over;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed plies plus randomized games
// against a transaction-level model of the game state and ply timing.
`timescale 1ns/1ps
module tb_game_sequencer;
  import go_pkg::*;

  localparam int TO = 4096;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            new_game = 1'b0;
  logic [1:0]      color_src = 2'b10;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0][7:0] req_move = '0;
  logic [1:0]      req_ready;
  logic            move_done, move_reject, upd_start, upd_turn;
  logic [1:0]      reject_code;
  board_t          upd_board, upd_ko_board, board;
  logic [7:0]      upd_move;
  board_t          upd_next_board = '0;
  logic            upd_valid = 1'b0, upd_invalid = 1'b0;
  logic            turn, game_over, timeout_err;
  logic [8:0]      move_count;

  game_sequencer #(.TIMEOUT_CYCLES(TO), .MOVE_CNT_W(9)) dut (
    .clk_in(clk), .rst_in(rst), .new_game(new_game), .color_src(color_src),
    .req_valid(req_valid), .req_move(req_move), .req_ready(req_ready),
    .move_done(move_done), .move_reject(move_reject), .reject_code(reject_code),
    .upd_start(upd_start), .upd_board(upd_board), .upd_ko_board(upd_ko_board),
    .upd_turn(upd_turn), .upd_move(upd_move), .upd_next_board(upd_next_board),
    .upd_valid(upd_valid), .upd_invalid(upd_invalid), .board(board), .turn(turn),
    .move_count(move_count), .game_over(game_over), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the game state
  board_t m_board, m_ko;
  logic   m_turn;
  int     m_count, m_pass;
  logic   m_over, m_terr, m_pend;

  // Per-cycle expectations for handshake and pulse outputs
  logic       chk_en = 1'b0;
  logic [1:0] e_ready = 2'b11;
  logic       e_done = 1'b0, e_rej = 1'b0, e_start = 1'b0, e_upd = 1'b0;
  logic [1:0] e_code = 2'b00;
  logic [7:0] e_mv = 8'h00;

  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("board", board, m_board);
      chk("turn", 162'(turn), 162'(m_turn));
      chk("move_count", 162'(move_count), 162'(m_count));
      chk("game_over", 162'(game_over), 162'(m_over));
      chk("timeout_err", 162'(timeout_err), 162'(m_terr));
      chk("req_ready", 162'(req_ready), 162'(e_ready));
      chk("move_done", 162'(move_done), 162'(e_done));
      chk("move_reject", 162'(move_reject), 162'(e_rej));
      chk("upd_start", 162'(upd_start), 162'(e_start));
      if (e_rej) chk("reject_code", 162'(reject_code), 162'(e_code));
      if (e_upd) begin
        chk("upd_board", upd_board, m_board);
        chk("upd_ko_board", upd_ko_board, m_ko);
        chk("upd_turn", 162'(upd_turn), 162'(m_turn));
        chk("upd_move", 162'(upd_move), 162'(e_mv));
      end
    end
  end

  task automatic model_reset();
    m_board = '0;
    m_ko    = '1;
    m_turn  = 1'b0;
    m_count = 0;
    m_pass  = 0;
    m_over  = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    e_done  = 1'b0;
    e_rej   = 1'b0;
    e_start = 1'b0;
  endtask

  function automatic board_t rand_board();
    board_t b;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 9; j++)
        b[i][j] = cell_t'($urandom_range(0, 3));
    return b;
  endfunction

  function automatic logic [1:0] idle_ready(input logic [1:0] v);
    return v[0] ? 2'b01 : 2'b11;
  endfunction

  // resp: 0 legal verdict, 1 illegal verdict, 2 no answer, 3 both verdicts.
  // Called at the start of an IDLE cycle; returns at the start of the next
  // IDLE (or GAME_OVER) cycle in which a request could be presented.
  task automatic do_move(input logic p, input logic [7:0] mv, input int resp, input int dly,
                         input logic hold1, input logic [7:0] mv1, input logic ng);
    logic [3:0] r, c;
    int         code;
    board_t     nb;
    r = mv[7:4];
    c = mv[3:0];
    req_valid    = 2'b00;
    req_valid[p] = 1'b1;
    req_move[p]  = mv;
    if (hold1) begin
      req_valid[1] = 1'b1;
      req_move[1]  = mv1;
    end
    e_ready = idle_ready(req_valid);
    next_cycle();
    req_valid = hold1 ? 2'b10 : 2'b00;
    e_ready   = 2'b00;
    if (p != color_src[m_turn])                            code = 0;
    else if (mv != 8'hFF && (r > 4'd8 || c > 4'd8))        code = 1;
    else if (mv != 8'hFF && m_board[r][c] != EMPTY)        code = 2;
    else                                                   code = -1;
    next_cycle();
    if (code >= 0) begin
      e_rej  = 1'b1;
      e_code = 2'(code);
      next_cycle();
    end else begin
      e_start = 1'b1;
      e_upd   = 1'b1;
      e_mv    = mv;
      next_cycle();
      if (ng) begin
        new_game = 1'b1;
        m_pend   = 1'b1;
      end
      if (resp == 2) begin
        for (int w = 0; w < TO; w++) begin
          next_cycle();
          new_game = 1'b0;
        end
        e_upd  = 1'b0;
        e_rej  = 1'b1;
        e_code = 2'd3;
        m_terr = 1'b1;
        next_cycle();
      end else begin
        for (int w = 0; w < dly; w++) begin
          next_cycle();
          new_game = 1'b0;
        end
        if (resp == 0 && mv != 8'hFF) begin
          nb = m_board;
          nb[r][c] = m_turn ? WHITE : BLACK;
          if ($urandom_range(0, 3) == 0) nb[$urandom_range(0, 8)][$urandom_range(0, 8)] = EMPTY;
          nb[r][c] = m_turn ? WHITE : BLACK;
        end else begin
          nb = rand_board();
        end
        upd_next_board = nb;
        upd_valid      = (resp == 0 || resp == 3);
        upd_invalid    = (resp == 1 || resp == 3);
        next_cycle();
        upd_valid   = 1'b0;
        upd_invalid = 1'b0;
        new_game    = 1'b0;
        e_upd       = 1'b0;
        if (resp == 0) begin
          e_done = 1'b1;
          if (mv == 8'hFF) begin
            m_ko   = '1;
            m_pass = m_pass + 1;
          end else begin
            m_ko    = m_board;
            m_board = nb;
            m_pass  = 0;
          end
          m_turn  = ~m_turn;
          m_count = (m_count == 511) ? 511 : m_count + 1;
          next_cycle();
          if (m_pass == 2) m_over = 1'b1;
        end else begin
          e_rej  = 1'b1;
          e_code = 2'd3;
          next_cycle();
        end
      end
    end
    if (m_pend) begin
      e_ready = 2'b00;
      next_cycle();
      model_reset();
    end
    e_ready = m_over ? 2'b00 : idle_ready(req_valid);
  endtask

  task automatic ng_idle();
    new_game = 1'b1;
    e_ready  = 2'b00;
    next_cycle();
    new_game = 1'b0;
    model_reset();
    e_ready = idle_ready(req_valid);
  endtask

  board_t     all_ko;
  logic [1:0] cell44;

  initial begin
    logic       force1;
    logic [7:0] fmv;
    model_reset();
    m_terr = 1'b0;
    all_ko = '1;
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    e_ready = 2'b11;
    chk_en  = 1'b1;

    chk("reset_board", board, '0);
    chk("reset_ko", upd_ko_board, all_ko);
    chk("reset_turn", 162'(turn), 162'(0));
    chk("reset_count", 162'(move_count), 162'(0));
    chk("reset_ready", 162'(req_ready), 162'(2'b11));

    color_src = 2'b10;
    do_move(1'b0, 8'h44, 0, 1, 1'b0, 8'h00, 1'b0);
    cell44 = board[4][4];
    chk("first_cell44", 162'(cell44), 162'(2'b01));
    chk("first_turn", 162'(turn), 162'(1));
    chk("first_count", 162'(move_count), 162'(1));
    chk("first_ko", upd_ko_board, '0);

    do_move(1'b0, 8'h55, 0, 0, 1'b0, 8'h00, 1'b0);
    do_move(1'b1, 8'h44, 0, 0, 1'b0, 8'h00, 1'b0);
    do_move(1'b1, 8'h9A, 0, 0, 1'b0, 8'h00, 1'b0);
    chk("rejects_count", 162'(move_count), 162'(1));

    do_move(1'b0, 8'h55, 0, 0, 1'b1, 8'h33, 1'b0);
    do_move(1'b1, 8'h33, 0, 0, 1'b0, 8'h00, 1'b0);
    chk("white_count", 162'(move_count), 162'(2));

    do_move(1'b0, 8'h22, 2, 0, 1'b0, 8'h00, 1'b0);
    chk("timeout_flag", 162'(timeout_err), 162'(1));
    do_move(1'b0, 8'h22, 0, 2, 1'b0, 8'h00, 1'b0);
    chk("after_timeout_count", 162'(move_count), 162'(3));

    do_move(1'b1, 8'h66, 0, 2, 1'b0, 8'h00, 1'b1);
    chk("deferred_ng_count", 162'(move_count), 162'(0));
    chk("deferred_ng_board", board, '0);
    chk("deferred_ng_terr", 162'(timeout_err), 162'(1));

    do_move(1'b0, 8'hFF, 0, 0, 1'b0, 8'h00, 1'b0);
    do_move(1'b1, 8'hFF, 0, 1, 1'b0, 8'h00, 1'b0);
    chk("over_flag", 162'(game_over), 162'(1));
    chk("over_count", 162'(move_count), 162'(2));
    chk("over_ready", 162'(req_ready), 162'(0));
    ng_idle();
    chk("restart_over", 162'(game_over), 162'(0));
    chk("restart_turn", 162'(turn), 162'(0));

    force1 = 1'b0;
    fmv    = 8'h00;
    for (int it = 0; it < 400; it++) begin
      logic       p, hold1, ng;
      logic [7:0] mv, mv1;
      int         k, resp;
      if (!force1) begin
        color_src = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) p = color_src[m_turn];
        else                           p = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 9);
        if (k == 0)      mv = 8'hFF;
        else if (k == 1) mv = {4'($urandom_range(9, 15)), 4'($urandom_range(0, 15))};
        else             mv = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
      end else begin
        p  = 1'b1;
        mv = fmv;
      end
      k = $urandom_range(0, 19);
      resp  = (k < 13) ? 0 : (k < 16) ? 1 : 3;
      hold1 = (p == 1'b0) && ($urandom_range(0, 4) == 0);
      mv1   = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
      ng    = ($urandom_range(0, 19) == 0);
      do_move(p, mv, resp, $urandom_range(0, 3), hold1, mv1, ng);
      force1 = hold1;
      fmv    = mv1;
      if (m_over || (!force1 && $urandom_range(0, 29) == 0)) ng_idle();
    end

    req_valid = 2'b00;
    e_ready   = m_over ? 2'b00 : 2'b11;
    next_cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Sits between move sources and board_updater, and sequences that engine for every ply.
- Shares the engine between two move requesters: port 0 is the local controls, port 1 is the remote link.
- Checks the source, coordinates and occupancy of each move before launching the engine.
- Owns the committed board, the ko board, the turn, the move count and pass/game-over tracking.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles WAIT_UPD may last before the attempt is treated as illegal.
- MOVE_CNT_W, 9: width of move_count.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-high.
- new_game  in  1  request to clear the board and restart.
- color_src  in  2  bit0 = port owning black, bit1 = port owning white.
- req_valid  in  2  per-port move request.
- req_move  in  2x8  per-port move; [7:4] row, [3:0] col, 8'hFF = pass.
- req_ready  out  2  per-port accept.
- move_done  out  1  one-cycle pulse: move committed.
- move_reject  out  1  one-cycle pulse: move refused.
- reject_code  out  2  reason for refusal; valid with move_reject.
- upd_start  out  1  start pulse to board_updater.
- upd_board  out  9x9x2  committed board presented to the engine.
- upd_ko_board  out  9x9x2  ko board presented to the engine.
- upd_turn  out  1  side to move, to the engine.
- upd_move  out  8  latched move, to the engine.
- upd_next_board  in  9x9x2  engine result.
- upd_valid  in  1  engine verdict: legal.
- upd_invalid  in  1  engine verdict: illegal.
- board  out  9x9x2  committed board.
- turn  out  1  0 = black to move, 1 = white to move.
- move_count  out  MOVE_CNT_W  committed moves, passes included.
- game_over  out  1  two consecutive passes seen.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
Encodings
- Cell values: 00 empty, 01 black, 10 white, 11 = ko sentinel only.

Reset
- board all 00; ko board all 11.
- turn=0, move_count=0, pass_cnt=0.
- game_over=0, timeout_err=0.
- All pulses 0; state IDLE.

States
- IDLE
  - req_ready = 2'b11.
  - Fixed priority: port 0 wins; the losing port stays unreadied.
  - On handshake: latch move and port, then go to CHECK.
- CHECK (1 cycle), evaluated in this order:
  1. Port ≠ color_src[turn] → REJECT, code 0.
  2. Move ≠ FF and (row>8 or col>8) → REJECT, code 1.
  3. Move ≠ FF and board[row][col] ≠ 00 → REJECT, code 2.
  4. Otherwise → LAUNCH.
- LAUNCH
  - upd_start=1 for exactly 1 cycle, then WAIT_UPD.
  - upd_board, upd_ko_board, upd_turn and upd_move are held stable from LAUNCH until the verdict.
- WAIT_UPD
  - Watchdog counter increments each cycle.
  - upd_valid → COMMIT.
  - upd_invalid → REJECT, code 3.
  - Counter reaches TIMEOUT_CYCLES → REJECT, code 3, and set timeout_err.
  - upd_valid and upd_invalid in the same cycle → upd_invalid wins.
- COMMIT
  - Non-pass: ko ← board, board ← upd_next_board, pass_cnt ← 0.
  - Pass: board unchanged, ko ← all 11, pass_cnt ← pass_cnt+1.
  - Always: turn toggles, move_count increments, saturating at max.
  - move_done pulses 1 cycle.
  - Next state: GAME_OVER if pass_cnt becomes 2, else IDLE.
- REJECT
  - move_reject pulses 1 cycle with reject_code.
  - Board, turn and count unchanged; → IDLE.
- GAME_OVER
  - game_over=1, req_ready=0.
  - Leave only via new_game.

new_game
- Honoured in IDLE or GAME_OVER: same result as reset, except timeout_err is kept.
- Arriving in any other state: latched and applied on the next entry to IDLE.
  - The in-flight move still completes or rejects first.
  - No request is accepted in that IDLE cycle.

Latency
- Reject at CHECK: move_reject 2 cycles after the handshake.
- Legal move: handshake → upd_start = 2 cycles; move_done = 1 cycle after upd_valid.

Decomposition:
- Shared package go_pkg:
  - cell_t (2-bit) and board_t (9x9 cell_t).
  - Constants EMPTY, BLACK, WHITE, KO_SENTINEL, PASS_MOVE=8'hFF.
  - Reject code enum: WRONG_SRC, OFF_BOARD, OCCUPIED, ILLEGAL.
- Natural sub-module: move_arbiter.
  - Two-port fixed-priority valid/ready arbiter.
  - Returns the granted port index and latched move.

Test Plan:
- Reset, color_src=2'b10; port0 sends 8'h44 → upd_start at T+2; engine returns board with 01 at [4][4] → move_done, turn=1, move_count=1, ko all 00.
- Then port0 sends 8'h55 while turn=1 → move_reject, code 0, no upd_start, board unchanged.
- Port1 sends 8'h44 (occupied) → code 2. Port1 sends 8'h9A → code 1. No upd_start in either case.
- Both ports valid in the same cycle → port0 granted; port1 req_ready=0 until IDLE returns.
- Engine never answers → reject code 3 after 4096 cycles, timeout_err=1; next legal move still commits.
- Black FF, white FF → game_over=1, move_count=2, req_ready=0. new_game asserted during WAIT_UPD is deferred, then clears the board, turn=0, game_over=0.
